mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the processor's data-memory port. Replaces the zero-latency data memory with a request/response handshake and configurable wait states, so the datapath can be driven by a multi-cycle or stalling controller. Accepts one word read or write, holds it for a fixed number of cycles, commits it to an internal word array, and returns read data plus an error status.

## Interface
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: word width.
- `DEPTH`, 64: number of words; must be a power of two.
- `WAIT_STATES`, 2: cycles spent in WAIT, ≥ 0.

Ports:
- `CLK`  in  1  clock; all logic acts on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  responder can accept a request.
- `ReqWrite`  in  1  1 = write, 0 = read.
- `ReqAddress`  in  ADDR_WIDTH  byte address.
- `ReqWriteData`  in  DATA_WIDTH  write word.
- `RespValid`  out  1  response present.
- `RespReady`  in  1  initiator consumes the response.
- `RespReadData`  out  DATA_WIDTH  read word; 0 for writes and errors.
- `RespError`  out  1  access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `ReqReady` = 1.
  - Accept on `ReqValid && ReqReady`: latch `ReqWrite`, `ReqAddress` and `ReqWriteData`. Request inputs may change after the accept.
  - Go to WAIT, or straight to the commit when `WAIT_STATES` = 0.
- **WAIT**
  - Counter counts `WAIT_STATES` cycles.
  - The commit happens on the edge that leaves WAIT:
    - a write stores the latched data to `mem[addr[log2(DEPTH)+1:2]]`;
    - a read loads `RespReadData`.
  - Go to RESP.
- **RESP**
  - `RespValid` = 1. `RespReadData` and `RespError` stay stable until `RespValid && RespReady`.
  - After that handshake: IDLE.
  - `ReqReady` = 0 in WAIT and RESP. There is no overlap between a response and the next accept.
- **Error checks** (with the macro, see Configuration):
  - Error when `ReqAddress[1:0]` ≠ 0, or when `ReqAddress[ADDR_WIDTH-1:2]` ≥ `DEPTH`.
  - On error: no write, `RespReadData` = 0, `RespError` = 1. The full latency is still spent.
- **Registered outputs and reset values:**
  - `ReqReady` = 1, `RespValid` = 0, `RespReadData` = 0, `RespError` = 0.
  - Memory contents are not reset. They are undefined at power-up and retained across `RST`.

## Timing
- **Latency:** accept in cycle N → `RespValid` high in cycle N+`WAIT_STATES`+1.
- **Throughput:** at best one transaction per `WAIT_STATES`+2 cycles. A response handshake in cycle M gives `ReqReady` = 1 in cycle M+1.
- **Reset priority:** `RST` has priority over every other input. A handshake in a cycle where `RST` = 1 is ignored.
- **Reset mid-operation:** the next cycle is IDLE, with all outputs at their reset values.
  - A write not yet committed is discarded.
  - A write committed on the same edge as `RST` is also discarded, because `RST` blocks the array write enable.
- **Backpressure:** `RespReady` low holds RESP indefinitely, with no change to any output.
- **Read data:** reflects array contents at the commit edge, including a write committed earlier by the previous transaction.

## Configuration
- `MEM_RESPONDER_ERROR_EN` defined:
  - alignment and range checks active as in Operation;
  - `RespError` is driven.
- Not defined:
  - `ReqAddress[1:0]` ignored;
  - word index is `ReqAddress[log2(DEPTH)+1:2]`, so out-of-range addresses alias modulo `DEPTH`;
  - `RespError` tied 0.

## Structure
- **Shared package / header `mem_bus_pkg`** contains:
  - FSM state encodings (IDLE = 0, WAIT = 1, RESP = 2, 2-bit);
  - default `ADDR_WIDTH` / `DATA_WIDTH`;
  - the word-index width function (`clog2(DEPTH)`).
- **One sub-module, `mem_array`:**
  - `DEPTH` × `DATA_WIDTH` storage;
  - synchronous write (`WE`, `Address`, `WriteData`);
  - combinational read.
- The FSM, wait counter and error logic stay in `mem_responder`.

## Test plan
- **Write then read, `WAIT_STATES` = 2:**
  - Write 0xDEADBEEF to 0x10, accepted in cycle 0 → `RespValid` in cycle 3 with `RespError` = 0.
  - Read 0x10 → `RespReadData` = 0xDEADBEEF.
- **Zero wait states:** `WAIT_STATES` = 0, read of a preloaded word → `RespValid` in the cycle after the accept with correct data.
- **Backpressure:** hold `RespReady` = 0 for 5 cycles → `RespValid`, `RespReadData` and `RespError` stable, `ReqReady` = 0 throughout; `ReqReady` = 1 the cycle after `RespReady` rises.
- **Errors, `MEM_RESPONDER_ERROR_EN` defined:**
  - Write to 0x13 → `RespError` = 1, and `mem` at 0x10 is unchanged.
  - Read of 0x100 with `DEPTH` = 64 → `RespError` = 1, `RespReadData` = 0.
- **Errors, macro undefined:** write 0x55 to 0x100 → `RespError` = 0, and a read of 0x0 returns 0x55.
- **Reset mid-write and back-to-back:**
  - Assert `RST` during WAIT of a write of 0x1234 to 0x20 → next cycle IDLE with `ReqReady` = 1 and `RespValid` = 0; `mem` at 0x20 keeps its old value.
  - Hold `ReqValid` high with two queued requests → the second is accepted exactly one cycle after the first response handshake.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Shared definitions for the data-memory request/response bus:
//   - state_t       : responder FSM encoding (IDLE = 0, WAIT = 1, RESP = 2)
//   - DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH : default bus widths
//   - idx_width()   : word-index width for a given array depth (clog2, min 1)
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array
//   DEPTH x DATA_WIDTH word storage with a synchronous write port and a
//   combinational read port. Contents are never reset.
// Ports:
//   CLK        in   clock, write on rising edge
//   WE         in   write enable
//   Address    in   word index (idx_width(DEPTH) bits)
//   WriteData  in   word to store
//   ReadData   out  word currently stored at Address
module mem_array
  import mem_bus_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                        CLK,
  input  logic                        WE,
  input  logic [idx_width(DEPTH)-1:0] Address,
  input  logic [DATA_WIDTH-1:0]       WriteData,
  output logic [DATA_WIDTH-1:0]       ReadData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[Address] <= WriteData;
    end
  end

  assign ReadData = mem[Address];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Data-memory responder: accepts one read or write request, spends
//   WAIT_STATES cycles in WAIT, commits to the word array on the edge that
//   leaves WAIT (or on the accept edge when WAIT_STATES = 0), then presents
//   the response until it is consumed.
//   Optional feature macro: MEM_RESPONDER_ERROR_EN enables alignment and
//   range checking and drives RespError; otherwise addresses alias modulo
//   DEPTH and RespError is tied low.
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   ReqValid/ReqReady          request handshake
//   ReqWrite, ReqAddress,
//   ReqWriteData               request payload (byte address)
//   RespValid/RespReady        response handshake
//   RespReadData, RespError    response payload
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [DATA_WIDTH-1:0] ReqWriteData,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [DATA_WIDTH-1:0] RespReadData,
  output logic                  RespError
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  leave_wait;
  logic                  commit;
  logic                  cmt_write;
  logic [ADDR_WIDTH-1:0] cmt_addr;
  logic [DATA_WIDTH-1:0] cmt_wdata;
  logic                  cmt_err;
  logic                  arr_we;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign accept     = (state_q == IDLE) && ReqValid;
  assign leave_wait = (state_q == WAIT) && (cnt_q == CNT_W'(WAIT_STATES - 1));

  // With no wait states the commit coincides with the accept, so the live
  // request inputs feed the array instead of the not-yet-loaded latches.
  assign commit    = (WAIT_STATES == 0) ? accept       : leave_wait;
  assign cmt_write = (WAIT_STATES == 0) ? ReqWrite     : write_q;
  assign cmt_addr  = (WAIT_STATES == 0) ? ReqAddress   : addr_q;
  assign cmt_wdata = (WAIT_STATES == 0) ? ReqWriteData : wdata_q;

`ifdef MEM_RESPONDER_ERROR_EN
  assign cmt_err   = (cmt_addr[1:0] != 2'b00) || ((cmt_addr >> (IDX_W + 2)) != '0);
  assign RespError = err_q;
`else
  logic unused_addr_bits;
  assign cmt_err          = 1'b0;
  assign unused_addr_bits = ^{cmt_addr[1:0], cmt_addr[ADDR_WIDTH-1:IDX_W+2], err_q};
  assign RespError        = 1'b0;
`endif

  // RST gates the write so a commit landing on a reset edge is dropped.
  assign arr_we = commit && cmt_write && !cmt_err && !RST;

  mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_array (
    .CLK       (CLK),
    .WE        (arr_we),
    .Address   (cmt_addr[IDX_W+1:2]),
    .WriteData (cmt_wdata),
    .ReadData  (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ReqValid)   state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (leave_wait) state_d = RESP;
      RESP:    if (RespReady)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (commit) begin
        rdata_q <= (cmt_write || cmt_err) ? '0 : arr_rdata;
        err_q   <= cmt_err;
      end
    end
  end

  // Request payload latches carry no reset; they are only read after an accept.
  always_ff @(posedge CLK) begin
    if (accept) begin
      write_q <= ReqWrite;
      addr_q  <= ReqAddress;
      wdata_q <= ReqWriteData;
    end
  end

  assign ReqReady     = (state_q == IDLE);
  assign RespValid    = (state_q == RESP);
  assign RespReadData = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_write, z_resp_ready;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_req_ready, z_resp_valid, z_resp_error;
  logic [31:0] z_resp_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(2)) dut (
    .CLK(clk), .RST(rst),
    .ReqValid(req_valid), .ReqReady(req_ready), .ReqWrite(req_write),
    .ReqAddress(req_addr), .ReqWriteData(req_wdata),
    .RespValid(resp_valid), .RespReady(resp_ready),
    .RespReadData(resp_rdata), .RespError(resp_error)
  );

  mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) dut_zw (
    .CLK(clk), .RST(rst),
    .ReqValid(z_req_valid), .ReqReady(z_req_ready), .ReqWrite(z_req_write),
    .ReqAddress(z_req_addr), .ReqWriteData(z_req_wdata),
    .RespValid(z_resp_valid), .RespReady(z_resp_ready),
    .RespReadData(z_resp_rdata), .RespError(z_resp_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full transaction on the WAIT_STATES = 2 instance; lat counts cycles
  // from the accept cycle to the first cycle with RespValid high.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_error;
  endtask

  task automatic z_xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d;
    z_resp_ready = 1'b1;
    @(negedge clk);
    z_req_valid = 1'b0;
    lat = 1;
    while (!z_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = z_resp_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, hs, acc, rsp;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", {31'd0, resp_error}, 32'd0);
    rst = 1'b0;

    // Write then read back
    xact(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("wr_latency", lat, 3);
    check("wr_error", {31'd0, er}, 32'd0);
    check("wr_rdata_zero", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("rd_latency", lat, 3);
    check("rd_data", rd, 32'hDEADBEEF);

    // Zero wait states: preload, then read
    z_xact(1'b1, 32'h8, 32'hCAFEF00D, rd, lat);
    check("zw_wr_latency", lat, 1);
    z_xact(1'b0, 32'h8, 32'h0, rd, lat);
    check("zw_rd_latency", lat, 1);
    check("zw_rd_data", rd, 32'hCAFEF00D);

    // Backpressure
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_ready_in_wait", {31'd0, req_ready}, 32'd0);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", {31'd0, resp_valid}, 32'd1);
      check("bp_data_held", resp_rdata, 32'hDEADBEEF);
      check("bp_err_held", {31'd0, resp_error}, 32'd0);
      check("bp_ready_low", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_after", {31'd0, req_ready}, 32'd1);
    check("bp_valid_after", {31'd0, resp_valid}, 32'd0);

    // Error handling / aliasing
`ifdef MEM_RESPONDER_ERROR_EN
    xact(1'b1, 32'h13, 32'h0BAD0BAD, rd, er, lat);
    check("err_misalign_flag", {31'd0, er}, 32'd1);
    check("err_misalign_lat", lat, 3);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("err_misalign_nowrite", rd, 32'hDEADBEEF);
    xact(1'b0, 32'h100, 32'h0, rd, er, lat);
    check("err_range_flag", {31'd0, er}, 32'd1);
    check("err_range_data", rd, 32'd0);
`else
    xact(1'b1, 32'h100, 32'h55, rd, er, lat);
    check("alias_wr_error", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h0, 32'h0, rd, er, lat);
    check("alias_rd_data", rd, 32'h55);
    check("alias_rd_error", {31'd0, er}, 32'd0);
`endif

    // Reset during WAIT of a write
    xact(1'b1, 32'h20, 32'h00000A0A, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstw_rdata", resp_rdata, 32'd0);
    xact(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("rstw_mem_kept", rd, 32'h00000A0A);

    // Reset on the commit edge
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h7777;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstc_resp_valid", {31'd0, resp_valid}, 32'd0);
    xact(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("rstc_mem_kept", rd, 32'h00000A0A);

    // Back-to-back with ReqValid held high
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h11;
    hs = -1; acc = -1; rsp = -1;
    for (int i = 0; i < 30 && acc < 0; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_write = 1'b0; req_addr = 32'h30; req_wdata = 32'h0;
      end
      if (resp_valid && hs < 0) hs = cyc;
      if (req_ready && hs >= 0) acc = cyc;
    end
    check("b2b_accept_cycle", acc, hs + 1);
    for (int i = 0; i < 20 && rsp < 0; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) rsp = cyc;
    end
    check("b2b_second_latency", rsp, acc + 3);
    check("b2b_second_data", resp_rdata, 32'h11);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
